// File: rtl/hemaia_clk_meas_pkg.sv
// Shared types and helpers for the clock frequency meter.
//   meas_state_e : reference-domain FSM states.
//   bin2gray / gray2bin : Gray conversion on MaxCountWidth-wide vectors. Callers zero-extend
//   narrower values and truncate the result, which is exact because upper zero bits do not
//   affect the lower result bits.
package hemaia_clk_meas_pkg;

  localparam int unsigned MaxCountWidth = 64;

  typedef enum logic [1:0] {
    StIdle,
    StMeasure,
    StDone
  } meas_state_e;

  function automatic logic [MaxCountWidth-1:0] bin2gray(input logic [MaxCountWidth-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [MaxCountWidth-1:0] gray2bin(input logic [MaxCountWidth-1:0] gray);
    logic [MaxCountWidth-1:0] bin;
    bin[MaxCountWidth-1] = gray[MaxCountWidth-1];
    for (int i = MaxCountWidth - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/hemaia_clock_freq_meter_if.sv
// Request/result bundle of the clock frequency meter.
//   start    : start request (sampled only while idle)
//   window   : window length in reference clock cycles
//   busy     : measurement in progress
//   valid    : one-cycle result strobe
//   count    : measured edge count
//   overflow : accumulator saturated during the last window
// master = requester (firmware/controller side), slave = the meter.
interface hemaia_clock_freq_meter_if #(
  parameter int unsigned CountWidth  = 16,
  parameter int unsigned WindowWidth = 16
) ();

  logic                   start;
  logic [WindowWidth-1:0] window;
  logic                   busy;
  logic                   valid;
  logic [CountWidth-1:0]  count;
  logic                   overflow;

  modport master (
    output start, window,
    input  busy, valid, count, overflow
  );

  modport slave (
    input  start, window,
    output busy, valid, count, overflow
  );

endinterface

// File: rtl/hemaia_gray_sync_counter.sv
// Free-running edge counter in the measured clock domain, carried into the reference
// domain as Gray code so every synchronizer sample is a valid (old or new) count.
//   clk_i, rst_ni           : reference clock / async active-low reset
//   meas_clk_i, meas_rst_ni : measured clock / async active-low reset
//   cur_o                   : binary count in the clk_i domain
module hemaia_gray_sync_counter
  import hemaia_clk_meas_pkg::*;
#(
  parameter int unsigned CountWidth = 16,
  parameter int unsigned SyncStages = 2  // at least 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  meas_clk_i,
  input  logic                  meas_rst_ni,
  output logic [CountWidth-1:0] cur_o
);

  logic [CountWidth-1:0] bin_q, bin_d;
  logic [CountWidth-1:0] gray_q, gray_d;

  (* keep = "true", dont_touch = "true" *) logic [CountWidth-1:0] sync_q [SyncStages];

  // Gray register tracks the incremented value so it stays aligned with bin_q.
  always_comb begin
    bin_d  = bin_q + CountWidth'(1);
    gray_d = CountWidth'(bin2gray(MaxCountWidth'(bin_d)));
  end

  always_ff @(posedge meas_clk_i or negedge meas_rst_ni) begin
    if (!meas_rst_ni) begin
      bin_q  <= '0;
      gray_q <= '0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SyncStages; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= gray_q;
      for (int i = 1; i < SyncStages; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign cur_o = CountWidth'(gray2bin(MaxCountWidth'(sync_q[SyncStages-1])));

endmodule

// File: rtl/hemaia_clock_freq_meter.sv
// Counts rising edges of meas_clk_i over a programmable window of clk_i cycles.
//   clk_i, rst_ni           : reference clock / async active-low reset
//   meas_clk_i, meas_rst_ni : clock under measurement / its async active-low reset
//   bus (slave)             : start/window request, busy/valid/count/overflow result
// A start with window == 0 is dropped; starts while busy are ignored.
module hemaia_clock_freq_meter
  import hemaia_clk_meas_pkg::*;
#(
  parameter int unsigned CountWidth  = 16,
  parameter int unsigned WindowWidth = 16,
  parameter int unsigned SyncStages  = 2
) (
  input logic                       clk_i,
  input logic                       rst_ni,
  input logic                       meas_clk_i,
  input logic                       meas_rst_ni,
  hemaia_clock_freq_meter_if.slave  bus
);

  logic [CountWidth-1:0]  cur, prev_q, delta;
  logic [CountWidth:0]    sum;
  logic [CountWidth-1:0]  acc_sat;
  logic                   ovf_sat;
  logic [CountWidth-1:0]  acc_q, acc_d;
  logic                   ovf_q, ovf_d;
  logic [WindowWidth-1:0] win_q, win_d;
  logic [WindowWidth-1:0] wcnt_q, wcnt_d;
  logic [CountWidth-1:0]  count_q, count_d;
  logic                   ovf_out_q, ovf_out_d;
  meas_state_e            state_q, state_d;

  hemaia_gray_sync_counter #(
    .CountWidth (CountWidth),
    .SyncStages (SyncStages)
  ) u_gray_sync_counter (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .meas_clk_i  (meas_clk_i),
    .meas_rst_ni (meas_rst_ni),
    .cur_o       (cur)
  );

  // Modulo subtraction keeps delta correct across counter wrap.
  always_comb begin
    delta   = cur - prev_q;
    sum     = {1'b0, acc_q} + {1'b0, delta};
    acc_sat = sum[CountWidth] ? '1 : sum[CountWidth-1:0];
    ovf_sat = ovf_q | sum[CountWidth];
  end

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    wcnt_d    = wcnt_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    count_d   = count_q;
    ovf_out_d = ovf_out_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start && (bus.window != '0)) begin
          win_d   = bus.window;
          acc_d   = '0;
          ovf_d   = 1'b0;
          wcnt_d  = '0;
          state_d = StMeasure;
        end
      end
      StMeasure: begin
        acc_d  = acc_sat;
        ovf_d  = ovf_sat;
        wcnt_d = wcnt_q + WindowWidth'(1);
        if (wcnt_q == win_q - WindowWidth'(1)) begin
          // Result registered here so count/overflow are already stable while valid is high.
          count_d   = acc_sat;
          ovf_out_d = ovf_sat;
          state_d   = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // prev follows cur every cycle, so the first window after reset sees no reset jump.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      prev_q    <= '0;
      win_q     <= '0;
      wcnt_q    <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      count_q   <= '0;
      ovf_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= cur;
      win_q     <= win_d;
      wcnt_q    <= wcnt_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      count_q   <= count_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  assign bus.busy     = (state_q != StIdle);
  assign bus.valid    = (state_q == StDone);
  assign bus.count    = count_q;
  assign bus.overflow = ovf_out_q;

endmodule

// File: tb/tb_hemaia_clock_freq_meter.sv
`timescale 1ns / 1ps
module tb_hemaia_clock_freq_meter;

  localparam realtime ClkPeriod = 10.0;

  typedef struct {
    real         ideal;  // edges expected in an exact window
    real         tol;    // allowed deviation in edges
    longint      maxv;   // saturation value of the accumulator
    longint      due;    // cycle index at which valid must appear
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic meas_clk = 1'b0;
  logic meas_rst_n = 1'b0;
  realtime meas_half = 0.0;  // 0 means measured clock stopped
  longint cyc = 0;

  int checks = 0;
  int errors = 0;

  exp_t q16[$];
  exp_t q8[$];

  hemaia_clock_freq_meter_if #(.CountWidth(16), .WindowWidth(16)) bus16 ();
  hemaia_clock_freq_meter_if #(.CountWidth(8),  .WindowWidth(16)) bus8 ();

  hemaia_clock_freq_meter #(
    .CountWidth  (16),
    .WindowWidth (16),
    .SyncStages  (2)
  ) dut16 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .meas_clk_i  (meas_clk),
    .meas_rst_ni (meas_rst_n),
    .bus         (bus16)
  );

  // Narrow accumulator measuring the reference clock itself, used for saturation.
  hemaia_clock_freq_meter #(
    .CountWidth  (8),
    .WindowWidth (16),
    .SyncStages  (2)
  ) dut8 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .meas_clk_i  (clk),
    .meas_rst_ni (meas_rst_n),
    .bus         (bus8)
  );

  always #(ClkPeriod / 2) clk = ~clk;

  always begin
    if (meas_half == 0.0) begin
      meas_clk = 1'b0;
      #1;
    end else begin
      #(meas_half) meas_clk = ~meas_clk;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input bit ok, input string name, input longint act,
                              input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic void score(input string nm, input exp_t e, input longint cnt,
                                input bit ovf, input longint now);
    real lo, hi;
    lo = e.ideal - e.tol;
    hi = e.ideal + e.tol;
    chk(now == e.due, {nm, " valid latency"}, now, e.due);
    if (lo > real'(e.maxv)) begin
      chk(cnt == e.maxv, {nm, " saturated count"}, cnt, e.maxv);
      chk(ovf == 1'b1, {nm, " overflow set"}, longint'(ovf), 1);
    end else begin
      chk(real'(cnt) >= lo && real'(cnt) <= hi, {nm, " count"}, cnt, longint'(e.ideal));
      if (hi < real'(e.maxv)) chk(ovf == 1'b0, {nm, " overflow clear"}, longint'(ovf), 0);
    end
  endfunction

  // Scoreboard monitor: every valid pops one expectation.
  always @(negedge clk) begin
    if (rst_n && bus16.valid) begin
      if (q16.size() == 0) chk(1'b0, "unexpected valid (16b)", 1, 0);
      else score("m16", q16.pop_front(), longint'(bus16.count), bus16.overflow, cyc);
    end
    if (rst_n && bus8.valid) begin
      if (q8.size() == 0) chk(1'b0, "unexpected valid (8b)", 1, 0);
      else score("m8", q8.pop_front(), longint'(bus8.count), bus8.overflow, cyc);
    end
  end

  // One measurement on the 16-bit meter. period == 0 stops the measured clock.
  task automatic run16(input int unsigned w, input realtime period, input bit poke);
    exp_t   e;
    longint k;
    meas_half = period / 2.0;
    repeat (8) @(negedge clk);
    k = cyc;
    bus16.window = 16'(w);
    bus16.start  = 1'b1;
    e.ideal = (period == 0.0) ? 0.0 : real'(w) * ClkPeriod / period;
    e.tol   = (period == 0.0) ? 0.0 : 1.001;
    e.maxv  = 65535;
    e.due   = k + w + 1;
    q16.push_back(e);
    @(negedge clk);
    bus16.start = 1'b0;
    chk(bus16.busy == 1'b1, "busy after start", longint'(bus16.busy), 1);
    for (int i = 0; i < int'(w) + 20 && bus16.busy; i++) begin
      bus16.start  = poke && (i == int'(w) / 2);
      bus16.window = poke ? 16'd5 : 16'(w);
      @(negedge clk);
    end
    bus16.start = 1'b0;
    chk(!bus16.busy && cyc == k + w + 2, "busy falls at T+win+2", cyc, k + w + 2);
  endtask

  task automatic run8(input int unsigned w);
    exp_t   e;
    longint k;
    repeat (4) @(negedge clk);
    k = cyc;
    bus8.window = 16'(w);
    bus8.start  = 1'b1;
    e.ideal = real'(w);
    e.tol   = 1.001;
    e.maxv  = 255;
    e.due   = k + w + 1;
    q8.push_back(e);
    @(negedge clk);
    bus8.start = 1'b0;
    for (int i = 0; i < int'(w) + 20 && bus8.busy; i++) @(negedge clk);
    chk(!bus8.busy && cyc == k + w + 2, "busy8 falls at T+win+2", cyc, k + w + 2);
  endtask

  initial begin
    bus16.start = 1'b0;
    bus16.window = '0;
    bus8.start = 1'b0;
    bus8.window = '0;

    @(negedge clk);
    chk(bus16.busy == 1'b0, "reset busy", longint'(bus16.busy), 0);
    chk(bus16.valid == 1'b0, "reset valid", longint'(bus16.valid), 0);
    chk(bus16.count == '0, "reset count", longint'(bus16.count), 0);
    chk(bus16.overflow == 1'b0, "reset overflow", longint'(bus16.overflow), 0);
    chk(bus8.busy == 1'b0, "reset busy8", longint'(bus8.busy), 0);
    chk(bus8.count == '0, "reset count8", longint'(bus8.count), 0);
    #2 meas_rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    run16(1000, 40.0, 1'b0);  // 25 MHz -> 250
    run16(300, 30.0, 1'b0);   // divide by 3 -> 100
    run16(300, 10.0, 1'b0);   // divide by 1 -> 300
    run8(300);                // saturates at 255
    run8(100);
    run16(200, 20.0, 1'b1);   // extra start mid-window must be ignored

    // Zero window: dropped entirely.
    @(negedge clk);
    bus16.window = '0;
    bus16.start  = 1'b1;
    @(negedge clk);
    bus16.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk(bus16.busy == 1'b0, "busy stays low on zero window", longint'(bus16.busy), 0);
      @(negedge clk);
    end

    run16(50, 0.0, 1'b0);     // stopped clock -> 0

    // Reset mid-window.
    run16(300, 30.0, 1'b0);   // leaves a non-zero result behind
    meas_half = 12.5;
    repeat (8) @(negedge clk);
    bus16.window = 16'd200;
    bus16.start  = 1'b1;
    @(negedge clk);
    bus16.start = 1'b0;
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk(bus16.busy == 1'b0, "mid reset busy", longint'(bus16.busy), 0);
    chk(bus16.valid == 1'b0, "mid reset valid", longint'(bus16.valid), 0);
    chk(bus16.count == '0, "mid reset count", longint'(bus16.count), 0);
    chk(bus16.overflow == 1'b0, "mid reset overflow", longint'(bus16.overflow), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    run16(300, 30.0, 1'b0);

    // Randomized windows and ratios.
    for (int n = 0; n < 8; n++) begin
      run16($urandom_range(1, 400), realtime'($urandom_range(4, 90)), 1'(n % 2));
    end

    for (int i = 0; i < 100 && (q16.size() != 0 || q8.size() != 0); i++) @(negedge clk);
    chk(q16.size() == 0, "pending 16b results", q16.size(), 0);
    chk(q8.size() == 0, "pending 8b results", q8.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
